// File: rtl/vend_sequencer_if.sv
// Handshake and status bundle between the vending sequencer (master) and the
// coin front end / actuator drivers (slave). vend_fault exists only with VEND_WATCHDOG_EN.
interface vend_sequencer_if #(
    parameter int CREDIT_W = 4
);
    logic [1:0]          coin;
    logic                cancel;
    logic                vend_req;
    logic                vend_ack;
    logic                pay_req;
    logic                pay_ack;
    logic [CREDIT_W-1:0] credit;
    logic                product;
    logic                coin_reject;
    logic                busy;
`ifdef VEND_WATCHDOG_EN
    logic                vend_fault;

    modport master (
        input  coin, cancel, vend_ack, pay_ack,
        output vend_req, pay_req, credit, product, coin_reject, busy, vend_fault
    );
    modport slave (
        output coin, cancel, vend_ack, pay_ack,
        input  vend_req, pay_req, credit, product, coin_reject, busy, vend_fault
    );
`else
    modport master (
        input  coin, cancel, vend_ack, pay_ack,
        output vend_req, pay_req, credit, product, coin_reject, busy
    );
    modport slave (
        output coin, cancel, vend_ack, pay_ack,
        input  vend_req, pay_req, credit, product, coin_reject, busy
    );
`endif
endinterface

// File: rtl/vend_sequencer.sv
// Vending transaction controller: coin credit, handshaked vend and one-coin change payout,
// inactivity refund. Define VEND_WATCHDOG_EN for the vend-ack watchdog and vend_fault pulse.
module vend_sequencer #(
    parameter int PRICE      = 3,
    parameter int TIMEOUT    = 15,
    parameter int MAX_CREDIT = 15,
    parameter int CREDIT_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    vend_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, COLLECT, VEND, PAYOUT} state_t;

    localparam int                  CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] ONE_C    = CREDIT_W'(1);
    localparam logic [CREDIT_W:0]   MAX_X    = (CREDIT_W + 1)'(MAX_CREDIT);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t              state;
    logic [CREDIT_W-1:0] credit_q;
    logic [CNT_W-1:0]    idle_cnt;
    logic                vend_req_q;
    logic                pay_req_q;
    logic                product_q;
    logic                coin_reject_q;
    logic                busy_q;
`ifdef VEND_WATCHDOG_EN
    logic [CNT_W-1:0]    wd_cnt;
    logic                vend_fault_q;
`endif

    logic [CREDIT_W:0]   coin_val;
    logic [CREDIT_W:0]   sum;
    logic                coin_hit;
    logic                fits;
    logic [CREDIT_W-1:0] credit_upd;

    always_comb begin
        // NOTE: default first so every path assigns coin_val and no latch is inferred.
        coin_val = '0;
        case (bus.coin)
            2'd1:    coin_val = (CREDIT_W + 1)'(1);
            2'd2:    coin_val = (CREDIT_W + 1)'(2);
            2'd3:    coin_val = (CREDIT_W + 1)'(5);
            default: coin_val = '0;
        endcase
    end

    assign coin_hit   = (bus.coin != 2'd0);
    assign sum        = {1'b0, credit_q} + coin_val;
    assign fits       = (sum <= MAX_X);
    assign credit_upd = (coin_hit && fits) ? sum[CREDIT_W-1:0] : credit_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            credit_q      <= '0;
            idle_cnt      <= '0;
            vend_req_q    <= 1'b0;
            pay_req_q     <= 1'b0;
            product_q     <= 1'b0;
            coin_reject_q <= 1'b0;
            busy_q        <= 1'b0;
`ifdef VEND_WATCHDOG_EN
            wd_cnt        <= '0;
            vend_fault_q  <= 1'b0;
`endif
        end else begin
            product_q     <= 1'b0;
            coin_reject_q <= 1'b0;
`ifdef VEND_WATCHDOG_EN
            vend_fault_q  <= 1'b0;
            if (state != VEND) wd_cnt <= '0;
`endif
            case (state)
                IDLE: begin
                    if (coin_hit) begin
                        if (fits) begin
                            credit_q <= credit_upd;
                            idle_cnt <= '0;
                            state    <= COLLECT;
                        end else begin
                            coin_reject_q <= 1'b1;
                        end
                    end
                end

                COLLECT: begin
                    if (bus.cancel) begin
                        coin_reject_q <= coin_hit;
                        pay_req_q     <= 1'b1;
                        busy_q        <= 1'b1;
                        state         <= PAYOUT;
                    end else if (credit_upd >= PRICE_C) begin
                        credit_q      <= credit_upd;
                        coin_reject_q <= coin_hit && !fits;
                        vend_req_q    <= 1'b1;
                        busy_q        <= 1'b1;
                        state         <= VEND;
                    end else if (coin_hit) begin
                        credit_q <= credit_upd;
                        if (fits) idle_cnt <= '0;
                        else      coin_reject_q <= 1'b1;
                    end else if (idle_cnt == CNT_LAST) begin
                        pay_req_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state     <= PAYOUT;
                    end else begin
                        idle_cnt <= idle_cnt + CNT_W'(1);
                    end
                end

                VEND: begin
                    coin_reject_q <= coin_hit;
                    if (bus.vend_ack && vend_req_q) begin
                        vend_req_q <= 1'b0;
                        product_q  <= 1'b1;
                        credit_q   <= credit_q - PRICE_C;
                        if (credit_q != PRICE_C) begin
                            pay_req_q <= 1'b1;
                            state     <= PAYOUT;
                        end else begin
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end
                    end
`ifdef VEND_WATCHDOG_EN
                    // Motor never answered: abandon the vend and refund everything.
                    else if (wd_cnt == CNT_LAST) begin
                        vend_req_q   <= 1'b0;
                        vend_fault_q <= 1'b1;
                        pay_req_q    <= 1'b1;
                        state        <= PAYOUT;
                    end else begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                    end
`endif
                end

                PAYOUT: begin
                    coin_reject_q <= coin_hit;
                    if (pay_req_q) begin
                        if (bus.pay_ack) begin
                            pay_req_q <= 1'b0;
                            credit_q  <= (credit_q != '0) ? credit_q - ONE_C : '0;
                            if (credit_q <= ONE_C) begin
                                busy_q <= 1'b0;
                                state  <= IDLE;
                            end
                        end
                    end else if (credit_q != '0) begin
                        pay_req_q <= 1'b1;
                    end else begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.vend_req    = vend_req_q;
    assign bus.pay_req     = pay_req_q;
    assign bus.credit      = credit_q;
    assign bus.product     = product_q;
    assign bus.coin_reject = coin_reject_q;
    assign bus.busy        = busy_q;
`ifdef VEND_WATCHDOG_EN
    assign bus.vend_fault  = vend_fault_q;
`endif
endmodule
